// File: rtl/pt_gen_serial.sv
// Serial pattern transmitter: shifts a latched PAT_W-bit pattern out MSB-first on d_o/valid_o,
// repeating it a programmed number of times with an optional idle gap between repetitions.
module pt_gen_serial #(
    parameter int unsigned PAT_W = 5,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned GAP_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic [CNT_W-1:0] repeat_i,
    input  logic [GAP_W-1:0] gap_i,
    input  logic             hold_i,
    output logic             d_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    localparam logic [BIT_W-1:0] BitLast = BIT_W'(PAT_W - 1);
    localparam logic [BIT_W-1:0] BitZero = '0;
    localparam logic [BIT_W-1:0] BitOne  = BIT_W'(1);
    localparam logic [CNT_W-1:0] RepOne  = CNT_W'(1);
    localparam logic [GAP_W-1:0] GapZero = '0;
    localparam logic [GAP_W-1:0] GapOne  = GAP_W'(1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StSend = 2'd1;
    localparam logic [1:0] StGap  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [PAT_W-1:0] shift_q, shift_d;
    logic [GAP_W-1:0] gap_lat_q, gap_lat_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             d_q, d_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        shift_d   = shift_q;
        gap_lat_d = gap_lat_q;
        rep_cnt_d = rep_cnt_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        d_d       = d_q;
        valid_d   = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (start_i) begin
                    pat_d     = pattern_i;
                    gap_lat_d = gap_i;
                    rep_cnt_d = repeat_i;
                    busy_d    = 1'b1;
                    if (repeat_i != '0) begin
                        shift_d   = pattern_i;
                        bit_cnt_d = BitZero;
                        gap_cnt_d = GapZero;
                        state_d   = StSend;
                    end else begin
                        state_d = StDone;
                    end
                end
            end

            StSend: begin
                // While stalled everything holds, including the last driven d_o.
                if (!hold_i) begin
                    valid_d   = 1'b1;
                    d_d       = shift_q[PAT_W-1];
                    shift_d   = {shift_q[PAT_W-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + BitOne;
                    if (bit_cnt_q == BitLast) begin
                        rep_cnt_d = rep_cnt_q - RepOne;
                        bit_cnt_d = BitZero;
                        if (rep_cnt_q == RepOne) begin
                            state_d = StDone;
                        end else begin
                            // Reload in the same cycle so gap=0 gives a seamless stream.
                            shift_d = pat_q;
                            if (gap_lat_q != GapZero) begin
                                state_d = StGap;
                            end
                        end
                    end
                end
            end

            StGap: begin
                d_d       = 1'b0;
                gap_cnt_d = gap_cnt_q + GapOne;
                if (gap_cnt_q == gap_lat_q - GapOne) begin
                    gap_cnt_d = GapZero;
                    state_d   = StSend;
                end
            end

            StDone: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= StIdle;
            pat_q     <= '0;
            shift_q   <= '0;
            gap_lat_q <= '0;
            rep_cnt_q <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            d_q       <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            shift_q   <= shift_d;
            gap_lat_q <= gap_lat_d;
            rep_cnt_q <= rep_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            d_q       <= d_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign d_o     = d_q;
    assign valid_o = valid_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_pt_gen_serial.sv
// Scoreboard bench for pt_gen_serial: stimulus queues timestamped expected bits and done pulses,
// a negedge monitor pops and compares them whenever valid_o or done_o is seen.
module tb_pt_gen_serial;

    localparam int PAT_W = 5;
    localparam int CNT_W = 8;
    localparam int GAP_W = 4;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             start_i;
    logic [PAT_W-1:0] pattern_i;
    logic [CNT_W-1:0] repeat_i;
    logic [GAP_W-1:0] gap_i;
    logic             hold_i;
    logic             d_o;
    logic             valid_o;
    logic             busy_o;
    logic             done_o;

    pt_gen_serial #(
        .PAT_W(PAT_W),
        .CNT_W(CNT_W),
        .GAP_W(GAP_W)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .pattern_i(pattern_i),
        .repeat_i (repeat_i),
        .gap_i    (gap_i),
        .hold_i   (hold_i),
        .d_o      (d_o),
        .valid_o  (valid_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int cyc;
        bit is_done;
        bit val;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: every bit or done pulse must match the head of the queue, timestamp included.
    always @(negedge clk_i) begin
        if (rst_i && (valid_o || done_o)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {30'd0, valid_o, done_o}, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("event_cycle", cyc, e.cyc);
                chk("event_kind", {31'd0, done_o}, {31'd0, e.is_done});
                if (!e.is_done) chk("bit_value", {31'd0, d_o}, {31'd0, e.val});
            end
        end
    end

    task automatic push(input int c, input bit is_done, input bit val);
        exp_t e;
        e.cyc     = c;
        e.is_done = is_done;
        e.val     = val;
        exp_q.push_back(e);
    endtask

    task automatic push_stream(input int c0, input logic [PAT_W-1:0] pat, input int rep,
                               input int gap);
        int t;
        t = c0 + 2;
        for (int r = 0; r < rep; r++) begin
            for (int i = 0; i < PAT_W; i++) begin
                push(t, 1'b0, pat[PAT_W-1-i]);
                t++;
            end
            if (r < rep - 1) t += gap;
        end
        push(t, 1'b1, 1'b0);
    endtask

    // Issues start at a negedge; returns the cycle number at that negedge (one before edge N).
    task automatic start_tx(input logic [PAT_W-1:0] pat, input int rep, input int gap,
                            output int c0);
        @(negedge clk_i);
        pattern_i = pat;
        repeat_i  = CNT_W'(rep);
        gap_i     = GAP_W'(gap);
        start_i   = 1'b1;
        c0        = cyc;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk_i);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(negedge clk_i);
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (2) @(negedge clk_i);
    endtask

    int c;

    initial begin
        rst_i     = 1'b0;
        start_i   = 1'b0;
        pattern_i = '0;
        repeat_i  = '0;
        gap_i     = '0;
        hold_i    = 1'b0;
        #1;
        chk("reset_d", {31'd0, d_o}, 0);
        chk("reset_valid", {31'd0, valid_o}, 0);
        chk("reset_busy", {31'd0, busy_o}, 0);
        chk("reset_done", {31'd0, done_o}, 0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;

        // Basic single repetition
        start_tx(5'b10110, 1, 0, c);
        push_stream(c, 5'b10110, 1, 0);
        chk("basic_busy_latency", {31'd0, busy_o}, 1);
        chk("basic_no_early_valid", {31'd0, valid_o}, 0);
        wait_cyc(c + 7);
        chk("basic_busy_after_done", {31'd0, busy_o}, 0);
        wait_drain();

        // Back-to-back repetitions; start pulse in the DONE cycle must be ignored
        start_tx(5'b10110, 3, 0, c);
        push_stream(c, 5'b10110, 3, 0);
        wait_cyc(c + 16);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        wait_drain();
        chk("b2b_done_start_ignored", {31'd0, busy_o}, 0);

        // Gap between repetitions
        start_tx(5'b11001, 2, 3, c);
        push_stream(c, 5'b11001, 2, 3);
        wait_cyc(c + 7);
        for (int i = 0; i < 3; i++) begin
            chk("gap_valid", {31'd0, valid_o}, 0);
            chk("gap_d", {31'd0, d_o}, 0);
            chk("gap_busy", {31'd0, busy_o}, 1);
            @(negedge clk_i);
        end
        wait_drain();

        // Hold after 2nd bit, ignored start pulses and input changes mid-run
        start_tx(5'b10110, 1, 0, c);
        push(c + 2, 1'b0, 1'b1);
        push(c + 3, 1'b0, 1'b0);
        push(c + 8, 1'b0, 1'b1);
        push(c + 9, 1'b0, 1'b1);
        push(c + 10, 1'b0, 1'b0);
        push(c + 11, 1'b1, 1'b0);
        pattern_i = 5'b01001;
        repeat_i  = 8'd7;
        gap_i     = 4'd5;
        wait_cyc(c + 3);
        hold_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start_i = ~start_i;
            @(negedge clk_i);
            chk("hold_valid", {31'd0, valid_o}, 0);
            chk("hold_d", {31'd0, d_o}, 0);
        end
        hold_i  = 1'b0;
        start_i = 1'b0;
        wait_drain();
        chk("hold_idle_after", {31'd0, busy_o}, 0);

        // Zero repeat
        start_tx(5'b10110, 0, 0, c);
        push(c + 2, 1'b1, 1'b0);
        chk("zero_busy_one_cycle", {31'd0, busy_o}, 1);
        @(negedge clk_i);
        chk("zero_busy_drop", {31'd0, busy_o}, 0);
        wait_drain();

        // Reset during the 3rd valid bit aborts without a done pulse
        start_tx(5'b10110, 3, 0, c);
        push(c + 2, 1'b0, 1'b1);
        push(c + 3, 1'b0, 1'b0);
        push(c + 4, 1'b0, 1'b1);
        wait_cyc(c + 4);
        #2;
        rst_i = 1'b0;
        #1;
        chk("abort_d", {31'd0, d_o}, 0);
        chk("abort_valid", {31'd0, valid_o}, 0);
        chk("abort_busy", {31'd0, busy_o}, 0);
        chk("abort_done", {31'd0, done_o}, 0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        chk("abort_bits_seen", exp_q.size(), 0);
        repeat (3) @(negedge clk_i);

        start_tx(5'b11001, 1, 0, c);
        push_stream(c, 5'b11001, 1, 0);
        wait_drain();

        chk("final_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
